mult_pipe_sm: RTL and testbench

- Parametrised pipelined shift-add multiplier for the parallel FIR datapath; the next generation of the unsigned one-bit-per-stage multiplier.
- Adds:
  - selectable signed (two's complement) or unsigned operation per operand pair;
  - K multiplier bits retired per stage, so depth is M/K;
  - a valid/ready handshake with full-pipeline back-pressure;
  - bubble tracking per stage.
- Sits between coefficient/sample registers and the FIR adder tree.

---
 rtl/mult_pipe_sm.sv | 117 +++++++++++
 tb/tb_mult_pipe_sm.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe_sm.sv
// Pipelined shift-add multiplier for the FIR datapath: K multiplier bits retired per
// stage, optional two's-complement operands, and a whole-pipeline valid/ready stall.
module mult_pipe_sm #(
  parameter int N         = 8,
  parameter int M         = 8,
  parameter int K         = 2,
  parameter int SIGNED_EN = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  output logic           in_ready,
  input  logic           sgn,
  input  logic [N-1:0]   mult1,
  input  logic [M-1:0]   mult2,
  input  logic           out_ready,
  output logic [N+M-1:0] result,
  output logic           rdy
);

  localparam int W = N + M;
  localparam int S = M / K;

  if (N < 2 || M < 2 || K < 1 || K > M || (M % K) != 0) begin : g_bad_params
    $error("mult_pipe_sm: need N,M >= 2 and M a positive multiple of K");
  end

  // Per-stage registers (_q) and the values each stage loads on an advancing edge (_d).
  logic         valid_q [S];
  logic         sign_q  [S];
  logic [W-1:0] a_q     [S];
  logic [M-1:0] b_q     [S];
  logic [W-1:0] p_q     [S];

  logic         valid_d [S];
  logic         sign_d  [S];
  logic [W-1:0] a_d     [S];
  logic [M-1:0] b_d     [S];
  logic [W-1:0] p_in    [S];
  logic [W-1:0] p_d     [S];

  logic         adv;

  // Handshake: an operand pair is taken on an edge where en && in_ready; a result is
  // handed over on an edge where rdy && out_ready. The whole pipe moves as one unit,
  // so it advances whenever the last stage is empty or being drained.
  assign adv      = !valid_q[S-1] || out_ready;
  assign in_ready = adv;
  assign rdy      = valid_q[S-1];
  assign result   = p_q[S-1];

  for (genvar j = 0; j < S; j++) begin : g_stage
    logic [W-1:0] p_acc;
    logic [M-1:0] b_sh;

    if (j == 0) begin : g_src_in
      logic sign_in;
      assign sign_in    = (SIGNED_EN != 0) ? sgn : 1'b0;
      assign valid_d[j] = en;
      assign sign_d[j]  = sign_in;
      assign a_d[j]     = sign_in ? {{M{mult1[N-1]}}, mult1} : {{M{1'b0}}, mult1};
      assign b_d[j]     = mult2;
      assign p_in[j]    = '0;
    end else begin : g_src_prev
      assign valid_d[j] = valid_q[j-1];
      assign sign_d[j]  = sign_q[j-1];
      assign a_d[j]     = a_q[j-1];
      assign b_d[j]     = b_q[j-1];
      assign p_in[j]    = p_q[j-1];
    end

    // The multiplier MSB carries negative weight for signed pairs, so its term is subtracted.
    always_comb begin
      p_acc = p_in[j];
      b_sh  = '0;
      for (int k = 0; k < K; k++) begin
        b_sh = b_d[j] >> (j * K + k);
        if (b_sh[0]) begin
          if ((j * K + k == M - 1) && sign_d[j]) begin
            p_acc = p_acc - (a_d[j] << (j * K + k));
          end else begin
            p_acc = p_acc + (a_d[j] << (j * K + k));
          end
        end
      end
    end

    assign p_d[j] = p_acc;
  end

  // Data only loads behind a valid token, so result keeps its last product while rdy=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < S; j++) begin
        valid_q[j] <= 1'b0;
        sign_q[j]  <= 1'b0;
        a_q[j]     <= '0;
        b_q[j]     <= '0;
        p_q[j]     <= '0;
      end
    end else if (adv) begin
      for (int j = 0; j < S; j++) begin
        valid_q[j] <= valid_d[j];
        if (valid_d[j]) begin
          sign_q[j] <= sign_d[j];
          a_q[j]    <= a_d[j];
          b_q[j]    <= b_d[j];
          p_q[j]    <= p_d[j];
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{a_q[S-1], b_q[S-1], sign_q[S-1], sgn};

endmodule

// File: tb/tb_mult_pipe_sm.sv
// Bench for mult_pipe_sm: four parameterisations share one stimulus stream and are
// checked against an integer-arithmetic product model and per-instance expected queues.
module tb_mult_pipe_sm;

  localparam int NI = 4;

  logic                 clk = 1'b0;
  logic                 rst_n, en, sgn, out_ready;
  logic [7:0]           mult1, mult2;
  logic [NI-1:0]        in_ready_w, rdy_w;
  logic [NI-1:0][15:0]  result_w;
  int                   checks = 0;
  int                   errors = 0;
  logic [15:0]          exp_q [NI][$];

  always #5 clk = ~clk;

  mult_pipe_sm #(.N(8), .M(8), .K(2), .SIGNED_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_ready(in_ready_w[0]), .sgn(sgn),
    .mult1(mult1), .mult2(mult2), .out_ready(out_ready), .result(result_w[0]), .rdy(rdy_w[0]));
  mult_pipe_sm #(.N(8), .M(8), .K(1), .SIGNED_EN(1)) u_k1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_ready(in_ready_w[1]), .sgn(sgn),
    .mult1(mult1), .mult2(mult2), .out_ready(out_ready), .result(result_w[1]), .rdy(rdy_w[1]));
  mult_pipe_sm #(.N(8), .M(8), .K(8), .SIGNED_EN(1)) u_k8 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_ready(in_ready_w[2]), .sgn(sgn),
    .mult1(mult1), .mult2(mult2), .out_ready(out_ready), .result(result_w[2]), .rdy(rdy_w[2]));
  mult_pipe_sm #(.N(8), .M(8), .K(2), .SIGNED_EN(0)) u_us (
    .clk(clk), .rst_n(rst_n), .en(en), .in_ready(in_ready_w[3]), .sgn(sgn),
    .mult1(mult1), .mult2(mult2), .out_ready(out_ready), .result(result_w[3]), .rdy(rdy_w[3]));

  function automatic int lat_of(input int i);
    case (i)
      0:       return 4;
      1:       return 8;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic sen_of(input int i);
    return (i != 3);
  endfunction

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    longint av, bv, p;
    av = longint'(a);
    bv = longint'(b);
    if (s && a[7]) av = av - 256;
    if (s && b[7]) bv = bv - 256;
    p = av * bv;
    return p[15:0];
  endfunction

  function automatic logic [7:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'h01;
      2:       return 8'h7F;
      3:       return 8'h80;
      4:       return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; out_ready = 1'b1; sgn = 1'b0; mult1 = '0; mult2 = '0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) exp_q[i].delete();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (rdy_w[i] !== 1'b0) $display("FAIL reset_rdy inst%0d got %b exp 0", i, rdy_w[i]);
      if (rdy_w[i] !== 1'b0) errors++;
      checks++;
      if (result_w[i] !== 16'h0) begin
        errors++;
        $display("FAIL reset_result inst%0d got %h exp 0000", i, result_w[i]);
      end
      checks++;
      if (in_ready_w[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready inst%0d got %b exp 1", i, in_ready_w[i]);
      end
    end
  endtask

  task automatic test_unsigned();
    logic [7:0]  a [2] = '{8'hFF, 8'h00};
    logic [7:0]  b [2] = '{8'hFF, 8'd37};
    logic [15:0] e [2] = '{16'hFE01, 16'h0000};
    do_reset();
    sgn = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      en = (c <= 2);
      if (c <= 2) begin mult1 = a[c-1]; mult2 = b[c-1]; end
      tick();
      checks++;
      if (rdy_w[0] !== (c >= 4 && c < 6)) begin
        errors++;
        $display("FAIL unsigned_rdy cycle%0d got %b exp %b", c, rdy_w[0], (c >= 4 && c < 6));
      end else if (c >= 4 && c < 6) begin
        checks++;
        if (result_w[0] !== e[c-4]) begin
          errors++;
          $display("FAIL unsigned_result cycle%0d got %h exp %h", c, result_w[0], e[c-4]);
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_signed();
    logic [7:0]  a [3] = '{8'h80, 8'h80, 8'hFF};
    logic [7:0]  b [3] = '{8'h80, 8'h7F, 8'h01};
    logic [15:0] e [3] = '{16'h4000, 16'hC080, 16'hFFFF};
    do_reset();
    sgn = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      en = (c <= 3);
      if (c <= 3) begin mult1 = a[c-1]; mult2 = b[c-1]; end
      tick();
      checks++;
      if (rdy_w[0] !== (c >= 4 && c < 7)) begin
        errors++;
        $display("FAIL signed_rdy cycle%0d got %b exp %b", c, rdy_w[0], (c >= 4 && c < 7));
      end else if (c >= 4 && c < 7) begin
        checks++;
        if (result_w[0] !== e[c-4]) begin
          errors++;
          $display("FAIL signed_result cycle%0d got %h exp %h", c, result_w[0], e[c-4]);
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_mixed();
    logic        s [2] = '{1'b0, 1'b1};
    logic [15:0] e [2] = '{16'h01FE, 16'hFFFE};
    do_reset();
    mult1 = 8'hFF;
    mult2 = 8'h02;
    for (int c = 1; c <= 8; c++) begin
      en = (c <= 2);
      if (c <= 2) sgn = s[c-1];
      tick();
      checks++;
      if (rdy_w[0] !== (c >= 4 && c < 6)) begin
        errors++;
        $display("FAIL mixed_rdy cycle%0d got %b exp %b", c, rdy_w[0], (c >= 4 && c < 6));
      end else if (c >= 4 && c < 6) begin
        checks++;
        if (result_w[0] !== e[c-4]) begin
          errors++;
          $display("FAIL mixed_result cycle%0d got %h exp %h", c, result_w[0], e[c-4]);
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_back_pressure();
    logic [7:0]  pa [6];
    logic [7:0]  pb [6];
    logic        ps [6];
    logic [15:0] hold_r;
    int          idx = 0;
    int          got = 0;
    int          stall = 0;
    bit          stalled_once = 0;
    do_reset();
    for (int p = 0; p < 6; p++) begin
      pa[p] = rand_op(); pb[p] = rand_op(); ps[p] = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < 40 && got < 6; c++) begin
      en = (idx < 6);
      if (idx < 6) begin mult1 = pa[idx]; mult2 = pb[idx]; sgn = ps[idx]; end
      out_ready = (stall == 0);
      #1;
      checks++;
      if (in_ready_w[0] !== (stall == 0)) begin
        errors++;
        $display("FAIL bp_in_ready cycle%0d got %b exp %b", c, in_ready_w[0], (stall == 0));
      end
      if (rdy_w[0] && out_ready) begin
        checks++;
        if (exp_q[0].size() == 0) begin
          errors++;
          $display("FAIL bp_extra cycle%0d got %h exp none", c, result_w[0]);
        end else begin
          if (result_w[0] !== exp_q[0][0]) begin
            errors++;
            $display("FAIL bp_result cycle%0d got %h exp %h", c, result_w[0], exp_q[0][0]);
          end
          void'(exp_q[0].pop_front());
          got++;
        end
      end
      hold_r = result_w[0];
      if (en && in_ready_w[0]) begin
        exp_q[0].push_back(ref_mul(pa[idx], pb[idx], ps[idx]));
        idx++;
      end
      tick();
      if (stall > 0) begin
        checks++;
        if (rdy_w[0] !== 1'b1 || result_w[0] !== hold_r) begin
          errors++;
          $display("FAIL bp_hold cycle%0d got rdy=%b res=%h exp rdy=1 res=%h", c, rdy_w[0], result_w[0], hold_r);
        end
        stall--;
      end
      if (!stalled_once && rdy_w[0]) begin
        stall = 3;
        stalled_once = 1;
      end
    end
    checks++;
    if (got != 6 || exp_q[0].size() != 0) begin
      errors++;
      $display("FAIL bp_count got %0d delivered %0d left exp 6 delivered 0 left", got, exp_q[0].size());
    end
    en = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      en = 1'b1; mult1 = rand_op(); mult2 = rand_op(); sgn = 1'($urandom_range(0, 1));
      tick();
    end
    en = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (rdy_w[i] !== 1'b0 || result_w[i] !== 16'h0) begin
        errors++;
        $display("FAIL midreset_clear inst%0d got rdy=%b res=%h exp rdy=0 res=0000", i, rdy_w[i], result_w[i]);
      end
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (rdy_w[i] !== 1'b0) begin
          errors++;
          $display("FAIL midreset_leak inst%0d cycle%0d got rdy=%b exp 0", i, c, rdy_w[i]);
        end
      end
    end
  endtask

  task automatic test_param_sweep();
    logic [7:0] a [8];
    logic [7:0] b [8];
    logic       s [8];
    int         idx;
    do_reset();
    a[0] = 8'hFF; b[0] = 8'hFF; s[0] = 1'b0;
    a[1] = 8'h80; b[1] = 8'h80; s[1] = 1'b1;
    a[2] = 8'hFF; b[2] = 8'h01; s[2] = 1'b1;
    a[3] = 8'h80; b[3] = 8'h7F; s[3] = 1'b1;
    for (int p = 4; p < 8; p++) begin
      a[p] = rand_op(); b[p] = rand_op(); s[p] = 1'($urandom_range(0, 1));
    end
    for (int c = 1; c <= 17; c++) begin
      en = (c <= 8);
      if (c <= 8) begin mult1 = a[c-1]; mult2 = b[c-1]; sgn = s[c-1]; end
      tick();
      for (int i = 0; i < NI; i++) begin
        idx = c - lat_of(i);
        checks++;
        if (rdy_w[i] !== (idx >= 0 && idx < 8)) begin
          errors++;
          $display("FAIL sweep_rdy inst%0d cycle%0d got %b exp %b", i, c, rdy_w[i], (idx >= 0 && idx < 8));
        end else if (idx >= 0 && idx < 8) begin
          checks++;
          if (result_w[i] !== ref_mul(a[idx], b[idx], s[idx] & sen_of(i))) begin
            errors++;
            $display("FAIL sweep_result inst%0d cycle%0d got %h exp %h", i, c, result_w[i],
                     ref_mul(a[idx], b[idx], s[idx] & sen_of(i)));
          end
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    int            acc_cnt = 0;
    int            pending;
    logic [NI-1:0] hold_v;
    logic [15:0]   hold_r [NI];
    bit            draining;
    do_reset();
    for (int cyc = 0; cyc < 8000; cyc++) begin
      draining = (acc_cnt >= 1000);
      pending = 0;
      for (int i = 0; i < NI; i++) pending += exp_q[i].size();
      if (draining && pending == 0) break;
      en = !draining && ($urandom_range(0, 9) < 8);
      out_ready = draining || ($urandom_range(0, 3) != 0);
      sgn = 1'($urandom_range(0, 1));
      mult1 = rand_op();
      mult2 = rand_op();
      #1;
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (in_ready_w[i] !== (!rdy_w[i] || out_ready)) begin
          errors++;
          $display("FAIL rand_in_ready inst%0d cycle%0d got %b exp %b", i, cyc, in_ready_w[i], (!rdy_w[i] || out_ready));
        end
        hold_v[i] = rdy_w[i] && !out_ready;
        hold_r[i] = result_w[i];
        if (rdy_w[i] && out_ready) begin
          checks++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL rand_extra inst%0d cycle%0d got %h exp none", i, cyc, result_w[i]);
          end else begin
            if (result_w[i] !== exp_q[i][0]) begin
              errors++;
              $display("FAIL rand_result inst%0d cycle%0d got %h exp %h", i, cyc, result_w[i], exp_q[i][0]);
            end
            void'(exp_q[i].pop_front());
          end
        end
        if (en && in_ready_w[i]) begin
          exp_q[i].push_back(ref_mul(mult1, mult2, sgn & sen_of(i)));
          if (i == 0) acc_cnt++;
        end
      end
      tick();
      for (int i = 0; i < NI; i++) begin
        if (hold_v[i]) begin
          checks++;
          if (rdy_w[i] !== 1'b1 || result_w[i] !== hold_r[i]) begin
            errors++;
            $display("FAIL rand_hold inst%0d cycle%0d got rdy=%b res=%h exp rdy=1 res=%h", i, cyc, rdy_w[i], result_w[i], hold_r[i]);
          end
        end
      end
    end
    checks++;
    if (acc_cnt < 1000) begin
      errors++;
      $display("FAIL rand_accepted got %0d exp 1000", acc_cnt);
    end
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL rand_leftover inst%0d got %0d pending exp 0", i, exp_q[i].size());
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_mixed();
    test_back_pressure();
    test_reset_midflight();
    test_param_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
